// File: rtl/seq_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_stage_ctrl
// Description : Sequencing controller for a non-pipelined Y86 datapath.
//               Steps one instruction at a time through FETCH, DECODE,
//               EXECUTE, MEMORY, WRITEBACK and PCUPDATE.
//               Drives one-hot stage enables, the condition-code write
//               enable, a retire pulse and the Y86 status code.
//               MEMORY waits on mem_ready for load/store/stack icodes, and
//               gives up after MEM_TIMEOUT cycles.
//               Optional performance counters are built only when the
//               macro SEQ_PERF_COUNT_EN is defined. Otherwise both counter
//               outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_stage_ctrl #(
   parameter int MEM_TIMEOUT = 16   // legal range 1..255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  icode,
   input  logic        instr_valid,
   input  logic        imem_error,
   input  logic        mem_ready,
   input  logic        dmem_error,
   output logic        en_fetch,
   output logic        en_decode,
   output logic        en_execute,
   output logic        en_memory,
   output logic        en_writeback,
   output logic        en_pc,
   output logic        cc_we,
   output logic        retired,
   output logic        busy,
   output logic [2:0]  stat,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_MEMORY    = 3'd4,
      ST_WRITEBACK = 3'd5,
      ST_PCUPDATE  = 3'd6,
      ST_STOP      = 3'd7
   } state_t;

   localparam logic [2:0] C_STAT_AOK = 3'd1;
   localparam logic [2:0] C_STAT_HLT = 3'd2;
   localparam logic [2:0] C_STAT_ADR = 3'd3;
   localparam logic [2:0] C_STAT_INS = 3'd4;

   localparam logic [3:0] C_ICODE_HALT = 4'h0;
   localparam logic [3:0] C_ICODE_OPQ  = 4'h6;

   // Last wait-count value before the MEMORY timeout fires.
   localparam logic [7:0] C_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [2:0] stat_q,  stat_d;
   logic [3:0] icode_q, icode_d;
   logic [7:0] wait_q,  wait_d;
   logic       mem_op_w;

   // Instructions that touch data memory and must handshake on mem_ready:
   // rmmovq, mrmovq, call, ret, pushq, popq.
   assign mem_op_w = (icode_q == 4'h4) || (icode_q == 4'h5) ||
                     (icode_q == 4'h8) || (icode_q == 4'h9) ||
                     (icode_q == 4'hA) || (icode_q == 4'hB);

   // State, status, latched icode and MEMORY wait counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         stat_q  <= C_STAT_AOK;
         icode_q <= 4'h0;
         wait_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         stat_q  <= stat_d;
         icode_q <= icode_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state logic. Fault causes are resolved in priority order.
   always_comb begin
      state_d = state_q;
      stat_d  = stat_q;
      icode_d = icode_q;
      wait_d  = wait_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            icode_d = icode;
            if (imem_error) begin
               stat_d  = C_STAT_ADR;
               state_d = ST_STOP;
            end else if (!instr_valid) begin
               stat_d  = C_STAT_INS;
               state_d = ST_STOP;
            end else if (icode == C_ICODE_HALT) begin
               stat_d  = C_STAT_HLT;
               state_d = ST_STOP;
            end else begin
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_d = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            // The wait counter restarts on every entry into MEMORY.
            wait_d  = 8'd0;
            state_d = ST_MEMORY;
         end
         ST_MEMORY: begin
            if (!mem_op_w) begin
               state_d = ST_WRITEBACK;
            end else if (dmem_error) begin
               stat_d  = C_STAT_ADR;
               state_d = ST_STOP;
            end else if (mem_ready) begin
               state_d = ST_WRITEBACK;
            end else if (wait_q == C_WAIT_LAST) begin
               // The memory never answered: treat it as an address fault.
               stat_d  = C_STAT_ADR;
               state_d = ST_STOP;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         ST_WRITEBACK: begin
            state_d = ST_PCUPDATE;
         end
         ST_PCUPDATE: begin
            state_d = ST_FETCH;
         end
         ST_STOP: begin
            state_d = ST_STOP;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Moore outputs decoded from the registered state only.
   always_comb begin
      en_fetch     = 1'b0;
      en_decode    = 1'b0;
      en_execute   = 1'b0;
      en_memory    = 1'b0;
      en_writeback = 1'b0;
      en_pc        = 1'b0;
      cc_we        = 1'b0;
      retired      = 1'b0;
      busy         = 1'b0;
      case (state_q)
         ST_FETCH: begin
            en_fetch = 1'b1;
            busy     = 1'b1;
         end
         ST_DECODE: begin
            en_decode = 1'b1;
            busy      = 1'b1;
         end
         ST_EXECUTE: begin
            en_execute = 1'b1;
            busy       = 1'b1;
            cc_we      = (icode_q == C_ICODE_OPQ);
         end
         ST_MEMORY: begin
            en_memory = 1'b1;
            busy      = 1'b1;
         end
         ST_WRITEBACK: begin
            en_writeback = 1'b1;
            busy         = 1'b1;
         end
         ST_PCUPDATE: begin
            en_pc   = 1'b1;
            busy    = 1'b1;
            retired = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign stat = stat_q;

`ifdef SEQ_PERF_COUNT_EN
   logic [31:0] cycle_cnt_q;
   logic [31:0] instr_cnt_q;

   // Performance counters: busy cycles and retired instructions, free-running wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt_q <= 32'd0;
         instr_cnt_q <= 32'd0;
      end else begin
         if (busy) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
         end
         if (retired) begin
            instr_cnt_q <= instr_cnt_q + 32'd1;
         end
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`else
   assign cycle_cnt = 32'd0;
   assign instr_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
